mestpro_v3_core: RTL



---
 rtl/mestpro_v3_core.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mestpro_v3_core.sv
// mestpro_v3_core: accumulator core with register file, Z/C/N flags,
// sticky illegal-instruction flag and valid/ready handshakes on both the
// instruction input and the one-entry result buffer.
module mestpro_v3_core #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              INSTR_VALID,
  input  logic [7:0]        INSTRUCTION,
  output logic              INSTR_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [2:0]        FLAGS,
  output logic              ERR
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_OUT  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_MOV  = 4'd10;
  localparam logic [3:0] OP_CLR  = 4'd11;

  // Architectural state
  logic [DATA_W-1:0] acc_reg;
  logic [DATA_W-1:0] rf_reg [NREG];
  logic [2:0]        flags_reg;     // {N, C, Z}
  logic              err_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg;

  // Decode
  logic [3:0]        opcode;
  logic [3:0]        ridx;
  logic              instr_ready;
  logic              accept;
  logic              uses_r;
  logic              illegal;
  logic              exec;

  // Datapath
  logic [DATA_W-1:0] operand;
  logic [DATA_W:0]   add_full;
  logic [DATA_W:0]   sub_full;
  logic [DATA_W-1:0] acc_next;
  logic              c_next;
  logic              z_next;
  logic              n_next;
  logic              acc_write;

  // Register-file write port
  logic [NREG-1:0]   rf_we;
  logic [DATA_W-1:0] rf_wdata;

  assign opcode = INSTRUCTION[7:4];
  assign ridx   = INSTRUCTION[3:0];

  // The buffer frees up in the same cycle it drains, so a waiting OUT can
  // follow a delivered result without a bubble.
  assign instr_ready = !out_valid_reg || OUT_READY;
  assign accept      = INSTR_VALID && instr_ready;

  // Only register-addressing opcodes care about the index range
  always_comb begin
    uses_r = 1'b0;
    case (opcode)
      OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: uses_r = 1'b1;
      default: uses_r = 1'b0;
    endcase
  end

  assign illegal = (opcode >= 4'd12) || (uses_r && ({1'b0, ridx} >= 5'(NREG)));
  assign exec    = accept && !illegal;

  // Register-file read mux; out-of-range indices read zero (they are illegal anyway)
  always_comb begin
    operand = '0;
    for (int i = 0; i < NREG; i++) begin
      if (ridx == 4'(i)) operand = rf_reg[i];
    end
  end

  // Borrow falls out as the top bit of the widened subtraction
  assign add_full = {1'b0, acc_reg} + {1'b0, operand};
  assign sub_full = {1'b0, acc_reg} - {1'b0, operand};

  // ALU: next accumulator value and carry for ACC-writing opcodes
  always_comb begin
    acc_next  = acc_reg;
    c_next    = 1'b0;
    acc_write = 1'b0;
    case (opcode)
      OP_ADD: begin
        acc_next  = add_full[DATA_W-1:0];
        c_next    = add_full[DATA_W];
        acc_write = 1'b1;
      end
      OP_SUB: begin
        acc_next  = sub_full[DATA_W-1:0];
        c_next    = sub_full[DATA_W];
        acc_write = 1'b1;
      end
      OP_AND: begin
        acc_next  = acc_reg & operand;
        acc_write = 1'b1;
      end
      OP_OR: begin
        acc_next  = acc_reg | operand;
        acc_write = 1'b1;
      end
      OP_XOR: begin
        acc_next  = acc_reg ^ operand;
        acc_write = 1'b1;
      end
      OP_SHL: begin
        acc_next  = {acc_reg[DATA_W-2:0], 1'b0};
        c_next    = acc_reg[DATA_W-1];
        acc_write = 1'b1;
      end
      OP_SHR: begin
        acc_next  = {1'b0, acc_reg[DATA_W-1:1]};
        c_next    = acc_reg[0];
        acc_write = 1'b1;
      end
      OP_CLR: begin
        acc_next  = '0;
        acc_write = 1'b1;
      end
      default: begin
        acc_next  = acc_reg;
        acc_write = 1'b0;
      end
    endcase
  end

  assign z_next = (acc_next == '0);
  assign n_next = acc_next[DATA_W-1];

  // LOAD writes the operand input, MOV writes the accumulator
  assign rf_wdata = (opcode == OP_LOAD) ? IN_DATA : acc_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_rf_we
      assign rf_we[gi] = exec && (ridx == 4'(gi)) &&
                         ((opcode == OP_LOAD) || (opcode == OP_MOV));
    end
  endgenerate

  // Register file update
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NREG; i++) rf_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (rf_we[i]) rf_reg[i] <= rf_wdata;
      end
    end
  end

  // Accumulator, flags, sticky error and the one-entry output buffer
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      acc_reg       <= '0;
      flags_reg     <= 3'b000;
      err_reg       <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (accept && illegal) err_reg <= 1'b1;

      if (exec && acc_write) begin
        acc_reg   <= acc_next;
        flags_reg <= {n_next, c_next, z_next};
      end

      // A reload wins over a drain so OUT_VALID stays high across both
      if (exec && (opcode == OP_OUT)) begin
        out_data_reg  <= acc_reg;
        out_valid_reg <= 1'b1;
      end else if (out_valid_reg && OUT_READY) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign INSTR_READY = instr_ready;
  assign OUT_DATA    = out_data_reg;
  assign OUT_VALID   = out_valid_reg;
  assign FLAGS       = flags_reg;
  assign ERR         = err_reg;

endmodule
